// File: rtl/dual_up_counter.sv
// dual_up_counter
//   Two free-running WIDTH-bit up-counters on a shared clock and reset:
//   a synchronous binary counter and an asynchronous ripple counter built
//   from a chain of toggle flops. Once the ripple has settled, both carry
//   the same count.
//
// Parameters
//   WIDTH       counter width, 2..16
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous reset, active HIGH despite the name
//   out_sync    synchronous counter value
//   out_ripple  ripple counter value
//   wrap        one-cycle pulse in the cycle out_sync reads 0 after all-ones
//   mismatch    (only with DUAL_COUNTER_MISMATCH_EN) sticky flag, set if the
//               sampled ripple count ever differs from the synchronous count
//
// Optional build macro: DUAL_COUNTER_MISMATCH_EN

// One ripple stage: toggles on every rising edge of its clock input.
module dual_up_counter_tff (
    input  logic clk,
    input  logic rst,
    output logic q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else     q <= ~q;
    end
endmodule

module dual_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    output logic [WIDTH-1:0] out_sync,
    output logic [WIDTH-1:0] out_ripple,
`ifdef DUAL_COUNTER_MISMATCH_EN
    output logic             mismatch,
`endif
    output logic             wrap
);

    // Synchronous counter and its wrap pulse. wrap is registered from the
    // pre-increment value, so it lands in the cycle out_sync reads 0.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            out_sync <= '0;
            wrap     <= 1'b0;
        end else begin
            out_sync <= out_sync + 1'b1;
            wrap     <= (out_sync == {WIDTH{1'b1}});
        end
    end

    // Ripple chain: stage 0 runs off clk; stage i runs off the inverted
    // output of stage i-1, so it toggles when that bit falls 1->0.
    logic [WIDTH-1:0] rclk;
    assign rclk[0] = clk;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_rclk
            assign rclk[i] = ~out_ripple[i-1];
        end
        for (i = 0; i < WIDTH; i++) begin : g_stage
            dual_up_counter_tff u_tff (
                .clk (rclk[i]),
                .rst (rstn),
                .q   (out_ripple[i])
            );
        end
    endgenerate

`ifdef DUAL_COUNTER_MISMATCH_EN
    // The ripple value is sampled at clk through two stages; out_sync is
    // delayed by the same two stages so both samples refer to one cycle.
    // Sampling at the edge captures the value settled during the prior cycle.
    logic [WIDTH-1:0] rip_s1, rip_s2, syn_d1, syn_d2;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            rip_s1   <= '0;
            rip_s2   <= '0;
            syn_d1   <= '0;
            syn_d2   <= '0;
            mismatch <= 1'b0;
        end else begin
            rip_s1 <= out_ripple;
            rip_s2 <= rip_s1;
            syn_d1 <= out_sync;
            syn_d2 <= syn_d1;
            if (rip_s2 != syn_d2) mismatch <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_up_counter.sv
module tb_dual_up_counter;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [3:0] s4, r4;
    logic       w4;
    logic [7:0] s8, r8;
    logic       w8;
`ifdef DUAL_COUNTER_MISMATCH_EN
    logic       m4, m8;
`endif

    dual_up_counter #(.WIDTH(4)) u4 (
        .clk        (clk),
        .rstn       (rstn),
        .out_sync   (s4),
        .out_ripple (r4),
`ifdef DUAL_COUNTER_MISMATCH_EN
        .mismatch   (m4),
`endif
        .wrap       (w4)
    );

    dual_up_counter #(.WIDTH(8)) u8 (
        .clk        (clk),
        .rstn       (rstn),
        .out_sync   (s8),
        .out_ripple (r8),
`ifdef DUAL_COUNTER_MISMATCH_EN
        .mismatch   (m8),
`endif
        .wrap       (w8)
    );

    always #5 clk = ~clk;

    // Reference model: number of counted edges since the last reset. Every
    // expected output is derived from this with plain arithmetic.
    int edges = 0;
    always @(posedge clk or posedge rstn) begin
        if (rstn) edges = 0;
        else      edges = edges + 1;
    end

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;
    int wraps8 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle compare at the falling edge, once the ripple has settled.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("sync4",   32'(s4), 32'(edges % 16));
            check("ripple4", 32'(r4), 32'(edges % 16));
            check("wrap4",   32'(w4), 32'(edges > 0 && edges % 16 == 0));
            check("sync8",   32'(s8), 32'(edges % 256));
            check("ripple8", 32'(r8), 32'(edges % 256));
            check("wrap8",   32'(w8), 32'(edges > 0 && edges % 256 == 0));
`ifdef DUAL_COUNTER_MISMATCH_EN
            check("mismatch4", 32'(m4), 32'd0);
            check("mismatch8", 32'(m8), 32'd0);
`endif
            if (w8) wraps8++;
        end
    end

    // Assert reset a little after a falling edge and release it before the
    // next rising edge (never coincident with a clock edge).
    task automatic reset_pulse(input int hold);
        @(negedge clk);
        #1 rstn = 1'b1;
        repeat (hold) @(negedge clk);
        #3 rstn = 1'b0;
    endtask

    initial begin
        // Reset asserted before the first clock edge.
        #0 rstn = 1'b1;
        #1;
        check("pre_clk_sync",   32'(s4), 32'd0);
        check("pre_clk_ripple", 32'(r4), 32'd0);
        check("pre_clk_wrap",   32'(w4), 32'd0);

        // Reset hold for 5 cycles, checked every cycle by the compare process.
        cmp_en = 1'b1;
        repeat (5) @(negedge clk);

        // Release between edges; first edge gives 1.
        #2 rstn = 1'b0;
        @(posedge clk); #1;
        check("first_sync",   32'(s4), 32'd1);
        check("first_ripple", 32'(r4), 32'd1);
        repeat (9) @(posedge clk); #1;
        check("tenth_sync",   32'(s4), 32'hA);
        check("tenth_ripple", 32'(r4), 32'hA);
        repeat (5) @(posedge clk); #1;
        check("e15_sync",   32'(s4), 32'hF);
        check("e15_wrap",   32'(w4), 32'd0);
        @(posedge clk); #1;
        check("e16_sync",   32'(s4), 32'h0);
        check("e16_ripple", 32'(r4), 32'h0);
        check("e16_wrap",   32'(w4), 32'd1);
        @(posedge clk); #1;
        check("e17_wrap",   32'(w4), 32'd0);

        // Equality sweep.
        repeat (40) @(negedge clk);

        // Mid-count reset at count 7.
        for (int i = 0; i < 40 && (edges % 16) != 7; i++) @(negedge clk);
        check("reach7", 32'(s4), 32'd7);
        #2 rstn = 1'b1;
        #1;
        check("midrst_sync",   32'(s4), 32'd0);
        check("midrst_ripple", 32'(r4), 32'd0);
        check("midrst_wrap",   32'(w4), 32'd0);
        #1 rstn = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            check("resume_sync",   32'(s4), 32'(k));
            check("resume_ripple", 32'(r4), 32'(k));
        end

        // Randomized run lengths and reset pulses.
        for (int it = 0; it < 20; it++) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            reset_pulse($urandom_range(1, 3));
        end

        // WIDTH=8 wrap: 256 edges from reset release, single wrap pulse.
        reset_pulse(2);
        wraps8 = 0;
        repeat (255) @(posedge clk); #1;
        check("w8_e255_sync",   32'(s8), 32'hFF);
        check("w8_e255_ripple", 32'(r8), 32'hFF);
        @(posedge clk); #1;
        check("w8_e256_sync",   32'(s8), 32'h00);
        check("w8_e256_ripple", 32'(r8), 32'h00);
        check("w8_e256_wrap",   32'(w8), 32'd1);
        repeat (10) @(negedge clk);
        check("w8_pulse_count", 32'(wraps8), 32'd1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dual_up_counter.md
Name: dual_up_counter

Overview:
- Holds two free-running WIDTH-bit binary up-counters that share one clock and one reset.
- One counter is fully synchronous. The other is an asynchronous ripple counter built from a toggle-flop chain.
- Used as a timebase and counter-structure comparison block. After ripple settling, both outputs carry the same count every cycle.

Parameters:
- WIDTH, 4, bit width of both counters (legal range 2..16).

Ports:
- clk  input  1  clock; all counting is referenced to its rising edge.
- rstn  input  1  asynchronous reset, active-high despite the port name; 1 clears everything, 0 allows counting.
- out_sync  output  WIDTH  synchronous counter value.
- out_ripple  output  WIDTH  ripple counter value.
- wrap  output  1  registered pulse, high for one cycle on the edge where out_sync goes from all-ones to 0.

Behaviour:
- Reset:
  - While rstn=1: out_sync=0, out_ripple=0, wrap=0, held immediately without waiting for clk.
  - Reset asserted mid-count clears all outputs at once; any ripple in progress is aborted.
- Synchronous counter:
  - On each rising clk edge with rstn=0: out_sync <= out_sync + 1, modulo 2^WIDTH.
  - Latency: the first rising edge after rstn falls gives out_sync=1.
  - Wrap: all-ones -> 0, no saturation.
- Ripple counter:
  - Bit 0 toggles on every rising clk edge with rstn=0.
  - Bit i (i>=1) toggles on the falling edge of bit i-1, i.e. when bit i-1 goes 1->0. This makes an up-count.
  - Each flop has the async clear tied to rstn.
  - Intermediate values may appear during rippling. Once settled, after at most WIDTH flop delays and before the next rising clk edge, out_ripple equals out_sync.
  - Wrap: all-ones -> 0, with the carry rippling through all bits.
- wrap output:
  - Registered on the synchronous counter: wrap <= (out_sync == all-ones) && rstn=0.
  - Therefore wrap=1 in the same cycle in which out_sync reads 0 after a wrap.
  - Never high during reset or on the first count after reset.
- Reset release:
  - rstn deasserting between edges: counting starts at the next rising edge.
  - rstn deasserting coincident with an edge: that edge does not count.
- Structure: no enable, no load, no down-count. Both counters advance unconditionally out of reset.

Optional Feature:
- Macro: DUAL_COUNTER_MISMATCH_EN.
- When defined:
  - Adds output port mismatch (1 bit).
  - On each rising clk edge, out_ripple is sampled through two registered stages, and that sample is compared against out_sync delayed to match the same cycle.
  - mismatch is a sticky flag: set to 1 if the two ever differ, cleared only by rstn=1.
  - Reset value is 0.
- When not defined:
  - The port and all its logic are absent.
  - The block has only the ports listed above.

Test Plan:
- Reset hold: rstn=1 for 5 cycles -> out_sync=0, out_ripple=0, wrap=0 throughout, also asserted before the first clk edge.
- First count: release rstn between edges -> after the 1st rising edge out_sync=1 and out_ripple=1; after the 10th, both =0xA.
- Wrap: run 16 edges from reset release (WIDTH=4) -> the 15th edge gives 0xF, the 16th gives 0x0 on both counters, with wrap=1 for exactly that one cycle.
- Equality sweep: check at each falling clk edge over 40 cycles -> out_ripple == out_sync every cycle; no mismatch if DUAL_COUNTER_MISMATCH_EN is defined.
- Mid-count reset: assert rstn at count 0x7, asynchronously between edges -> both outputs become 0 immediately; after release, counting resumes 1,2,3…
- Parameter check: WIDTH=8, run 256 edges -> both counters wrap 0xFF->0x00, with a single wrap pulse.
